// File: rtl/fc_score_accum_if.sv
// Bus bundle for fc_score_accum: feature stream handshake, weight ROM port,
// the ten class scores and status. The slave modport is the accumulator's
// view and the master modport is the upstream/ROM/comparator side.
interface fc_score_accum_if #(
  parameter int FEAT_W  = 8,
  parameter int WGT_W   = 8,
  parameter int ADDR_W  = 10,
  parameter int SCORE_W = 25
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [FEAT_W-1:0]     in_data;
  logic                  w_rd;
  logic [ADDR_W-1:0]     w_addr;
  logic [10*WGT_W-1:0]   w_data;
  logic [SCORE_W-1:0]    score0;
  logic [SCORE_W-1:0]    score1;
  logic [SCORE_W-1:0]    score2;
  logic [SCORE_W-1:0]    score3;
  logic [SCORE_W-1:0]    score4;
  logic [SCORE_W-1:0]    score5;
  logic [SCORE_W-1:0]    score6;
  logic [SCORE_W-1:0]    score7;
  logic [SCORE_W-1:0]    score8;
  logic [SCORE_W-1:0]    score9;
  logic                  score_valid;
  logic                  busy;

  modport slave (
    input  start, in_valid, in_data, w_data,
    output in_ready, w_rd, w_addr,
           score0, score1, score2, score3, score4,
           score5, score6, score7, score8, score9,
           score_valid, busy
  );

  modport master (
    output start, in_valid, in_data, w_data,
    input  in_ready, w_rd, w_addr,
           score0, score1, score2, score3, score4,
           score5, score6, score7, score8, score9,
           score_valid, busy
  );
endinterface

// File: rtl/fc_score_accum.sv
// Output-layer accumulator of the digit classifier. Streams N_IN unsigned
// features, multiplies each against ten signed weights returned by an
// external synchronous ROM one cycle after the read, and publishes ten
// clamped unsigned scores with a one-cycle score_valid pulse.
module fc_score_accum #(
  parameter int FEAT_W  = 8,
  parameter int WGT_W   = 8,
  parameter int N_IN    = 196,
  parameter int ADDR_W  = 10,
  parameter int ACC_W   = 27,
  parameter int SCORE_W = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fc_score_accum_if.slave      bus
);
  localparam int N_CLS  = 10;
  localparam int PROD_W = FEAT_W + WGT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_IN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_FLUSH = 3'd2,
    S_CLAMP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [FEAT_W-1:0]   feat_q, feat_d;
  logic                mac_pend_q, mac_pend_d;
  logic                score_valid_q, score_valid_d;
  logic                clear_acc;
  logic                load_scores;
  logic                handshake;
  logic signed [PROD_W-1:0] feat_x;

  assign handshake = bus.in_valid & (state_q == S_ACCUM);

  // Feature is zero-extended to a positive signed value before the multiply.
  assign feat_x = PROD_W'($signed({1'b0, feat_q}));

  // Next-state and control decode for the frame sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    feat_d        = feat_q;
    mac_pend_d    = 1'b0;
    score_valid_d = 1'b0;
    clear_acc     = 1'b0;
    load_scores   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_ACCUM;
          cnt_d     = '0;
          clear_acc = 1'b1;
        end
      end
      S_ACCUM: begin
        if (handshake) begin
          feat_d     = bus.in_data;
          mac_pend_d = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // The MAC for the last feature lands during this cycle.
      S_FLUSH: state_d = S_CLAMP;
      S_CLAMP: begin
        load_scores   = 1'b1;
        score_valid_d = 1'b1;
        state_d       = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer, feature and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      feat_q        <= '0;
      mac_pend_q    <= 1'b0;
      score_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      feat_q        <= feat_d;
      mac_pend_q    <= mac_pend_d;
      score_valid_q <= score_valid_d;
    end
  end

  // One accumulator and one clamped score register per class.
  for (genvar gi = 0; gi < N_CLS; gi++) begin : g_cls
    logic signed [PROD_W-1:0] wgt_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [SCORE_W-1:0]       score_q, score_d;

    assign wgt_x = PROD_W'($signed(bus.w_data[gi*WGT_W +: WGT_W]));
    assign prod  = feat_x * wgt_x;

    // Accumulate the pending product; a new frame zeroes the sum.
    always_comb begin
      acc_d = acc_q;
      if (clear_acc) begin
        acc_d = '0;
      end else if (mac_pend_q) begin
        acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
    end

    // Saturate the signed sum into the unsigned score range.
    always_comb begin
      score_d = score_q;
      if (load_scores) begin
        if (acc_q[ACC_W-1]) begin
          score_d = '0;
        end else if (|acc_q[ACC_W-2:SCORE_W]) begin
          score_d = '1;
        end else begin
          score_d = acc_q[SCORE_W-1:0];
        end
      end
    end

    // Accumulator and score storage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q   <= '0;
        score_q <= '0;
      end else begin
        acc_q   <= acc_d;
        score_q <= score_d;
      end
    end
  end

  assign bus.in_ready    = (state_q == S_ACCUM);
  assign bus.busy        = (state_q == S_ACCUM) || (state_q == S_FLUSH) ||
                           (state_q == S_CLAMP);
  assign bus.w_rd        = handshake;
  assign bus.w_addr      = cnt_q;
  assign bus.score_valid = score_valid_q;
  assign bus.score0      = g_cls[0].score_q;
  assign bus.score1      = g_cls[1].score_q;
  assign bus.score2      = g_cls[2].score_q;
  assign bus.score3      = g_cls[3].score_q;
  assign bus.score4      = g_cls[4].score_q;
  assign bus.score5      = g_cls[5].score_q;
  assign bus.score6      = g_cls[6].score_q;
  assign bus.score7      = g_cls[7].score_q;
  assign bus.score8      = g_cls[8].score_q;
  assign bus.score9      = g_cls[9].score_q;
endmodule
